// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: latches one pending event per channel and serialises them round-robin
// onto a single valid/ready stream. Optional capture timestamps with EDGE_ARB_TIMESTAMP_EN.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
`ifdef EDGE_ARB_TIMESTAMP_EN
  ,
  parameter int TS_W = 16
`endif
) (
  input  logic            sync_clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] ev_in,
  input  logic [N_CH-1:0] ch_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
`ifdef EDGE_ARB_TIMESTAMP_EN
  output logic [TS_W-1:0] out_ts,
`endif
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state, state_next;
  logic [N_CH-1:0] ev_d;
  logic [N_CH-1:0] ev_new;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] ovf_set;
  logic [CH_W-1:0] rr;
  logic [CH_W-1:0] winner;
  logic            found;

  assign ev_new   = ev_in & ~ev_d & ch_en;
  assign eligible = pend & ch_en;

  // Round-robin: lowest eligible channel above rr, otherwise wrap to the lowest eligible overall.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i] && (i > int'(rr))) begin
        found  = 1'b1;
        winner = CH_W'(i);
      end
    end
    if (!found) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          found  = 1'b1;
          winner = CH_W'(i);
        end
      end
    end
  end

  assign grant   = (state == IDLE && found) ? (N_CH'(1) << winner) : '0;
  assign ovf_set = ev_new & pend & ~grant;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = OFFER;
      OFFER:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == OFFER);

  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A new event on a channel being granted this cycle re-arms pend without an overrun.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_d   <= '0;
      pend   <= '0;
      ovf    <= '0;
      rr     <= CH_W'(N_CH - 1);
      out_ch <= '0;
    end else begin
      ev_d <= ev_in;
      pend <= ((pend & ~grant) | ev_new) & ch_en;
      ovf  <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
      if (grant != '0) begin
        out_ch <= winner;
        rr     <= winner;
      end
    end
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_cap [N_CH];

  // Overrun events are discarded, so they must not disturb the pending event's timestamp.
  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      out_ts <= '0;
      for (int i = 0; i < N_CH; i++) ts_cap[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (ev_new[i] && !ovf_set[i]) ts_cap[i] <= ts_cnt;
      end
      if (grant != '0) out_ts <= ts_cap[winner];
    end
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a round-robin reference model.
module tb_edge_event_arbiter;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int TS_W   = 4;
  localparam int TS_MOD = 1 << TS_W;

  logic            sync_clk;
  logic            reset_n;
  logic [N_CH-1:0] ev_in;
  logic [N_CH-1:0] ch_en;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [N_CH-1:0] ovf;
  logic            ovf_clr;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] out_ts;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit m_busy;
  int m_ch, m_ts, m_rr, m_cnt;
  bit m_pend [N_CH];
  bit m_ovf  [N_CH];
  bit m_prev [N_CH];
  int m_tscap[N_CH];

  bit nx_busy;
  int nx_ch, nx_ts, nx_rr, nx_cnt;
  bit nx_pend [N_CH];
  bit nx_ovf  [N_CH];
  bit nx_prev [N_CH];
  int nx_tscap[N_CH];

  int beat_ch[$];
  int beat_ts[$];

`ifdef EDGE_ARB_TIMESTAMP_EN
  edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .TS_W(TS_W)) dut (
    .sync_clk(sync_clk), .reset_n(reset_n), .ev_in(ev_in), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_ts(out_ts),
    .ovf(ovf), .ovf_clr(ovf_clr));
`else
  edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
    .sync_clk(sync_clk), .reset_n(reset_n), .ev_in(ev_in), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .ovf(ovf), .ovf_clr(ovf_clr));
`endif

  initial sync_clk = 1'b0;
  always #5 sync_clk = ~sync_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ch = 0; m_ts = 0; m_rr = N_CH - 1; m_cnt = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 1'b0; m_ovf[i] = 1'b0; m_prev[i] = 1'b0; m_tscap[i] = 0;
    end
  endtask

  // Next state from the behavioural rules, using the inputs present before the edge.
  task automatic model_eval();
    bit evt[N_CH];
    bit gr[N_CH];
    bit overrun;
    int w;
    w = -1;
    for (int i = 0; i < N_CH; i++) begin
      evt[i] = ev_in[i] && !m_prev[i] && ch_en[i];
      gr[i]  = 1'b0;
    end
    nx_busy = m_busy; nx_ch = m_ch; nx_ts = m_ts; nx_rr = m_rr;
    if (!m_busy) begin
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (m_rr + k) % N_CH;
        if (w < 0 && m_pend[c] && ch_en[c]) w = c;
      end
      if (w >= 0) begin
        gr[w] = 1'b1; nx_busy = 1'b1; nx_ch = w; nx_ts = m_tscap[w]; nx_rr = w;
      end
    end else if (out_ready) begin
      nx_busy = 1'b0;
    end
    for (int i = 0; i < N_CH; i++) begin
      overrun      = evt[i] && m_pend[i] && !gr[i];
      nx_ovf[i]    = overrun || (m_ovf[i] && !ovf_clr);
      nx_pend[i]   = ch_en[i] && (evt[i] || (m_pend[i] && !gr[i]));
      nx_tscap[i]  = (evt[i] && !overrun) ? m_cnt : m_tscap[i];
      nx_prev[i]   = ev_in[i];
    end
    nx_cnt = (m_cnt + 1) % TS_MOD;
  endtask

  task automatic model_commit();
    m_busy = nx_busy; m_ch = nx_ch; m_ts = nx_ts; m_rr = nx_rr; m_cnt = nx_cnt;
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = nx_pend[i]; m_ovf[i] = nx_ovf[i]; m_prev[i] = nx_prev[i]; m_tscap[i] = nx_tscap[i];
    end
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] exp_ovf;
    for (int i = 0; i < N_CH; i++) exp_ovf[i] = m_ovf[i];
    check_output("out_valid", 32'(out_valid), 32'(m_busy));
    check_output("out_ch", 32'(out_ch), 32'(m_ch));
    check_output("ovf", 32'(ovf), 32'(exp_ovf));
`ifdef EDGE_ARB_TIMESTAMP_EN
    check_output("out_ts", 32'(out_ts), 32'(m_ts));
`endif
  endtask

  // One clock: log a handshake if it happens at this edge, step the model, compare after the edge.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_ch.push_back(int'(out_ch));
`ifdef EDGE_ARB_TIMESTAMP_EN
      beat_ts.push_back(int'(out_ts));
`else
      beat_ts.push_back(0);
`endif
    end
    model_eval();
    @(posedge sync_clk);
    #1;
    model_commit();
    compare_all();
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] ev, input int cycles);
    ev_in = ev;
    repeat (cycles) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ev_in = '0; ovf_clr = 1'b0; out_ready = 1'b0; ch_en = '1;
    repeat (2) @(posedge sync_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  initial begin
    int t_start;
    logic [CH_W-1:0] held_ch;
    int guard;

    reset_n = 1'b0; ev_in = '0; ch_en = '1; out_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    do_reset();

    // single stretched pulse on ch2
    $display("[TB] stretched pulse on channel 2");
    out_ready = 1'b1;
    beat_ch.delete(); beat_ts.delete();
    t_start = m_cnt;
    apply_stimulus(4'b0100, 2);
    check_output("pulse_latency_valid", 32'(out_valid), 32'd1);
    apply_stimulus(4'b0000, 8);
    check_output("pulse_beats", 32'(beat_ch.size()), 32'd1);
    if (beat_ch.size() > 0) check_output("pulse_ch", 32'(beat_ch[0]), 32'd2);
`ifdef EDGE_ARB_TIMESTAMP_EN
    if (beat_ts.size() > 0) check_output("pulse_ts", 32'(beat_ts[0]), 32'(t_start));
`endif

    // all channels at once from a fresh rr pointer
    $display("[TB] simultaneous events on all channels");
    do_reset();
    out_ready = 1'b1;
    beat_ch.delete(); beat_ts.delete();
    apply_stimulus(4'b1111, 1);
    apply_stimulus(4'b0000, 12);
    check_output("all_beats", 32'(beat_ch.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < beat_ch.size()) check_output("all_order", 32'(beat_ch[i]), 32'(i));
    check_output("all_no_ovf", 32'(ovf), 32'd0);

    // overrun on ch1 while the output is stalled
    $display("[TB] overrun and clear collision");
    out_ready = 1'b0;
    apply_stimulus(4'b0001, 1);
    apply_stimulus(4'b0000, 2);
    apply_stimulus(4'b0010, 1);
    apply_stimulus(4'b0000, 1);
    check_output("ovf1_first_edge", 32'(ovf[1]), 32'd0);
    apply_stimulus(4'b0010, 1);
    apply_stimulus(4'b0000, 1);
    check_output("ovf1_second_edge", 32'(ovf[1]), 32'd1);
    ovf_clr = 1'b1;
    apply_stimulus(4'b0010, 1);
    ovf_clr = 1'b0;
    apply_stimulus(4'b0000, 1);
    check_output("ovf1_set_wins", 32'(ovf[1]), 32'd1);

    // stalled offer stays stable; disabling ch3 drops its pending event
    $display("[TB] stall stability and channel disable");
    apply_stimulus(4'b1000, 1);
    apply_stimulus(4'b0000, 1);
    held_ch = out_ch;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("stall_valid", 32'(out_valid), 32'd1);
      check_output("stall_ch", 32'(out_ch), 32'(held_ch));
    end
    ch_en = 4'b0111;
    apply_stimulus(4'b0000, 1);
    ch_en = 4'b1111;
    beat_ch.delete(); beat_ts.delete();
    out_ready = 1'b1;
    apply_stimulus(4'b0000, 10);
    check_output("disable_beats", 32'(beat_ch.size()), 32'd2);
    foreach (beat_ch[i]) check_output("disable_no_ch3", 32'(beat_ch[i] == 3), 32'd0);

    // asynchronous reset while an event is on offer
    $display("[TB] reset during offer");
    out_ready = 1'b0;
    apply_stimulus(4'b0100, 1);
    apply_stimulus(4'b0000, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(out_valid), 32'd0);
    check_output("async_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge sync_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    beat_ch.delete(); beat_ts.delete();
    apply_stimulus(4'b0000, 6);
    check_output("post_rst_silent", 32'(beat_ch.size()), 32'd0);

`ifdef EDGE_ARB_TIMESTAMP_EN
    // timestamp wrap around 2^TS_W
    $display("[TB] timestamp wrap");
    guard = 0;
    while (m_cnt != TS_MOD - 1 && guard < 3 * TS_MOD) begin
      tick();
      guard++;
    end
    check_output("wrap_reached", 32'(m_cnt), 32'(TS_MOD - 1));
    beat_ch.delete(); beat_ts.delete();
    apply_stimulus(4'b0001, 1);
    apply_stimulus(4'b0000, 1);
    apply_stimulus(4'b0010, 1);
    apply_stimulus(4'b0000, 8);
    check_output("wrap_beats", 32'(beat_ts.size()), 32'd2);
    if (beat_ts.size() > 1) begin
      check_output("wrap_ts0", 32'(beat_ts[0]), 32'(TS_MOD - 1));
      check_output("wrap_ts1", 32'(beat_ts[1]), 32'd1);
    end
`else
    guard = 0;
`endif

    // random traffic against the model
    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      ev_in     = N_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      ch_en     = ($urandom_range(0, 7) == 0) ? N_CH'($urandom_range(0, 15)) : '1;
      tick();
    end
    ovf_clr = 1'b0; ch_en = '1; ev_in = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
